// File: rtl/rs_age_select.sv
// Reservation station with CDB wakeup (including dispatch bypass), per-class
// oldest-first selection through an age matrix, and full flush.
module rs_age_select #(
  parameter int unsigned RS_SIZE   = 16,
  parameter int unsigned DISP_W    = 3,
  parameter int unsigned CDB_W     = 3,
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned NUM_CLASS = 4,
  parameter int unsigned PAYLOAD_W = 64,
  parameter int unsigned CLASS_W   = $clog2(NUM_CLASS),
  parameter int unsigned CNT_W     = $clog2(RS_SIZE + 1)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic [DISP_W-1:0]                    disp_valid,
  input  logic [DISP_W-1:0][TAG_W-1:0]         disp_tag1,
  input  logic [DISP_W-1:0][TAG_W-1:0]         disp_tag2,
  input  logic [DISP_W-1:0]                    disp_rdy1,
  input  logic [DISP_W-1:0]                    disp_rdy2,
  input  logic [DISP_W-1:0][CLASS_W-1:0]       disp_class,
  input  logic [DISP_W-1:0][PAYLOAD_W-1:0]     disp_payload,
  input  logic [CDB_W-1:0]                     cdb_valid,
  input  logic [CDB_W-1:0][TAG_W-1:0]          cdb_tag,
  input  logic [NUM_CLASS-1:0]                 fu_ready,
  output logic [NUM_CLASS-1:0]                 issue_valid,
  output logic [NUM_CLASS-1:0][PAYLOAD_W-1:0]  issue_payload,
  output logic [CNT_W-1:0]                     free_cnt,
  output logic                                 rs_full,
  output logic                                 overflow_err
);

  logic [RS_SIZE-1:0]                   r_valid, r_rdy1, r_rdy2;
  logic [TAG_W-1:0]                     r_tag1    [RS_SIZE];
  logic [TAG_W-1:0]                     r_tag2    [RS_SIZE];
  logic [CLASS_W-1:0]                   r_class   [RS_SIZE];
  logic [PAYLOAD_W-1:0]                 r_payload [RS_SIZE];
  logic [RS_SIZE-1:0]                   r_older   [RS_SIZE];
  logic [NUM_CLASS-1:0]                 r_issue_valid;
  logic [NUM_CLASS-1:0][PAYLOAD_W-1:0]  r_issue_payload;
  logic [CNT_W-1:0]                     r_free_cnt;
  logic                                 r_rs_full, r_overflow;

  logic [RS_SIZE-1:0]                   w_hit1, w_hit2, w_ready, w_issued;
  logic [DISP_W-1:0]                    w_dhit1, w_dhit2;
  logic [NUM_CLASS-1:0][RS_SIZE-1:0]    w_cand, w_sel;
  logic [NUM_CLASS-1:0]                 w_iss_valid;
  logic [NUM_CLASS-1:0][PAYLOAD_W-1:0]  w_iss_pay;
  logic [RS_SIZE-1:0]                   w_wr, w_in_rdy1, w_in_rdy2;
  logic [TAG_W-1:0]                     w_in_tag1 [RS_SIZE];
  logic [TAG_W-1:0]                     w_in_tag2 [RS_SIZE];
  logic [CLASS_W-1:0]                   w_in_class [RS_SIZE];
  logic [PAYLOAD_W-1:0]                 w_in_pay  [RS_SIZE];
  logic [RS_SIZE-1:0]                   w_new_older [RS_SIZE];
  logic [RS_SIZE-1:0]                   w_older_nxt [RS_SIZE];
  logic                                 w_drop, w_found;
  logic [CNT_W-1:0]                     w_acc, w_iss_cnt, w_free_nxt;

  assign issue_valid   = r_issue_valid;
  assign issue_payload = r_issue_payload;
  assign free_cnt      = r_free_cnt;
  assign rs_full       = r_rs_full;
  assign overflow_err  = r_overflow;

  // Tag match of every broadcast against resident entries and dispatch lanes
  always_comb begin
    w_hit1  = '0;
    w_hit2  = '0;
    w_dhit1 = '0;
    w_dhit2 = '0;
    for (int k = 0; k < CDB_W; k++) begin
      if (cdb_valid[k]) begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (r_tag1[i] == cdb_tag[k]) w_hit1[i] = 1'b1;
          if (r_tag2[i] == cdb_tag[k]) w_hit2[i] = 1'b1;
        end
        for (int l = 0; l < DISP_W; l++) begin
          if (disp_tag1[l] == cdb_tag[k]) w_dhit1[l] = 1'b1;
          if (disp_tag2[l] == cdb_tag[k]) w_dhit2[l] = 1'b1;
        end
      end
    end
    w_ready = r_valid & (r_rdy1 | w_hit1) & (r_rdy2 | w_hit2);
  end

  // Per class: a candidate wins when no older candidate of the same class exists
  always_comb begin
    w_cand      = '0;
    w_sel       = '0;
    w_iss_valid = '0;
    w_iss_pay   = '0;
    w_issued    = '0;
    w_iss_cnt   = '0;
    for (int c = 0; c < NUM_CLASS; c++) begin
      for (int i = 0; i < RS_SIZE; i++)
        w_cand[c][i] = w_ready[i] && (r_class[i] == CLASS_W'(c));
      for (int i = 0; i < RS_SIZE; i++) begin
        w_sel[c][i] = fu_ready[c] && w_cand[c][i] && ((r_older[i] & w_cand[c]) == '0);
        if (w_sel[c][i]) w_iss_pay[c] = w_iss_pay[c] | r_payload[i];
      end
      w_iss_valid[c] = |w_sel[c];
      w_issued       = w_issued | w_sel[c];
      if (w_iss_valid[c]) w_iss_cnt = w_iss_cnt + CNT_W'(1);
    end
  end

  // Lanes in order claim the lowest slot that is invalid in the current state
  always_comb begin
    w_wr      = '0;
    w_in_rdy1 = '0;
    w_in_rdy2 = '0;
    w_drop    = 1'b0;
    w_found   = 1'b0;
    w_acc     = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      w_in_tag1[i]   = '0;
      w_in_tag2[i]   = '0;
      w_in_class[i]  = '0;
      w_in_pay[i]    = '0;
      w_new_older[i] = '0;
    end
    for (int l = 0; l < DISP_W; l++) begin
      if (disp_valid[l]) begin
        w_found = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
          if (!w_found && !r_valid[i] && !w_wr[i]) begin
            w_found        = 1'b1;
            w_new_older[i] = r_valid | w_wr;
            w_wr[i]        = 1'b1;
            w_in_tag1[i]   = disp_tag1[l];
            w_in_tag2[i]   = disp_tag2[l];
            w_in_rdy1[i]   = disp_rdy1[l] | w_dhit1[l];
            w_in_rdy2[i]   = disp_rdy2[l] | w_dhit2[l];
            w_in_class[i]  = disp_class[l];
            w_in_pay[i]    = disp_payload[l];
            w_acc          = w_acc + CNT_W'(1);
          end
        end
        if (!w_found) w_drop = 1'b1;
      end
    end
  end

  // A newly written slot is younger than everything; nobody is older than it
  always_comb begin
    for (int j = 0; j < RS_SIZE; j++)
      w_older_nxt[j] = w_wr[j] ? w_new_older[j] : (r_older[j] & ~w_wr);
  end

  assign w_free_nxt = r_free_cnt - w_acc + w_iss_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid         <= '0;
      r_rdy1          <= '0;
      r_rdy2          <= '0;
      r_issue_valid   <= '0;
      r_issue_payload <= '0;
      r_free_cnt      <= CNT_W'(RS_SIZE);
      r_rs_full       <= 1'b0;
      r_overflow      <= 1'b0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_tag1[i]    <= '0;
        r_tag2[i]    <= '0;
        r_class[i]   <= '0;
        r_payload[i] <= '0;
        r_older[i]   <= '0;
      end
    end else if (flush) begin
      r_valid       <= '0;
      r_issue_valid <= '0;
      r_free_cnt    <= CNT_W'(RS_SIZE);
      r_rs_full     <= 1'(RS_SIZE < DISP_W);
    end else begin
      r_valid       <= (r_valid & ~w_issued) | w_wr;
      r_rdy1        <= (w_wr & w_in_rdy1) | (~w_wr & (r_rdy1 | w_hit1));
      r_rdy2        <= (w_wr & w_in_rdy2) | (~w_wr & (r_rdy2 | w_hit2));
      r_issue_valid <= w_iss_valid;
      for (int c = 0; c < NUM_CLASS; c++)
        if (w_iss_valid[c]) r_issue_payload[c] <= w_iss_pay[c];
      for (int i = 0; i < RS_SIZE; i++) begin
        r_older[i] <= w_older_nxt[i];
        if (w_wr[i]) begin
          r_tag1[i]    <= w_in_tag1[i];
          r_tag2[i]    <= w_in_tag2[i];
          r_class[i]   <= w_in_class[i];
          r_payload[i] <= w_in_pay[i];
        end
      end
      r_free_cnt <= w_free_nxt;
      r_rs_full  <= (w_free_nxt < CNT_W'(DISP_W));
      r_overflow <= r_overflow | w_drop;
    end
  end

endmodule

// File: doc/rs_age_select.md
# rs_age_select

Parameterised reservation station for the out-of-order core. It sits between dispatch (downstream of ROB allocation) and the functional units. It accepts up to DISP_W instructions per cycle and wakes up operands from CDB_W CDB broadcasts, including a same-cycle bypass. Each cycle it issues at most one ready instruction per FU class, choosing the oldest by an age matrix, and it supports a full flush.

## Interface
Parameters:
- RS_SIZE, 16, number of entries (≥ DISP_W)
- DISP_W, 3, dispatch lanes per cycle
- CDB_W, 3, CDB broadcast ports
- TAG_W, 6, physical register tag width
- NUM_CLASS, 4, FU classes; one issue port per class
- PAYLOAD_W, 64, opaque instruction payload carried to the FU
- CLASS_W = $clog2(NUM_CLASS), CNT_W = $clog2(RS_SIZE+1) (derived)

Ports:
- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  squash all entries at next edge
- disp_valid  in  DISP_W  lane valid
- disp_tag1, disp_tag2  in  DISP_W×TAG_W  source tags
- disp_rdy1, disp_rdy2  in  DISP_W  source already ready; tag ignored when set
- disp_class  in  DISP_W×CLASS_W  FU class
- disp_payload  in  DISP_W×PAYLOAD_W  payload
- cdb_valid  in  CDB_W  broadcast valid
- cdb_tag  in  CDB_W×TAG_W  broadcast tag
- fu_ready  in  NUM_CLASS  class can accept an instruction this cycle
- issue_valid  out  NUM_CLASS  one-cycle issue pulse per class
- issue_payload  out  NUM_CLASS×PAYLOAD_W  issued payload
- free_cnt  out  CNT_W  registered count of free entries
- rs_full  out  1  free_cnt < DISP_W
- overflow_err  out  1  sticky; a lane was dropped because no entry was free

## Operation
- Entry state: valid, rdy1, rdy2, tag1, tag2, class, payload. Age matrix older[i][j] = 1 when entry j is older than entry i.
- Wakeup: every cycle, each valid entry sets rdyN when any cdb_valid[k] has cdb_tag[k] == tagN. Dispatch lanes are matched against the same CDB inputs in the same cycle, so a lane's stored rdyN = disp_rdyN | hit.
- Ready(i) = valid & (rdy1 | cur-cycle hit1) & (rdy2 | cur-cycle hit2). An entry woken this cycle is eligible for selection this cycle.
- Select: for class c with fu_ready[c] = 1, pick the ready entry of class c that has no older ready entry of class c. At the edge:
  - copy its payload to issue_payload[c];
  - set issue_valid[c];
  - invalidate the entry.
- Classes with no candidate, or with fu_ready = 0: issue_valid[c] = 0 and issue_payload[c] holds its previous value.
- Allocate: valid lanes in ascending lane order take free entries in ascending index order. Free means invalid in the current state; slots freed by this cycle's issue are not reused until the next cycle.
- Age update on write to slot i: older[i][j] = 1 for every currently valid j, and for same-cycle lanes with lower lane number. older[j][i] = 0 for all j.
- Overflow: valid lanes beyond the number of free entries are dropped and overflow_err sets. overflow_err clears only on reset.
- free_cnt(next) = free_cnt − accepted + issued. Flush forces RS_SIZE.
- Flush (sampled high at an edge):
  - all entries invalid;
  - issue_valid = 0 for every class;
  - same-cycle dispatch discarded;
  - payload registers held;
  - overflow_err unaffected.
- Reset values: all entries invalid, age matrix 0, issue_valid = 0, issue_payload = 0, free_cnt = RS_SIZE, rs_full = 0, overflow_err = 0.

## Timing
- Dispatch at edge t → entry visible in cycle t+1. Earliest issue_valid for a fully ready dispatch is cycle t+2.
- CDB tag in cycle t, entry already resident → issue_valid in cycle t+1 (zero-cycle wakeup-select).
- CDB tag coincident with dispatch of a dependent → captured as ready; same timing as a ready dispatch.
- issue_valid is high exactly one cycle per issued instruction. No backpressure after issue.
- free_cnt and rs_full are registered and reflect the state after the last edge. The dispatcher must not present more than free_cnt valid lanes.
- Reset assertion is asynchronous at any point, including mid-issue: outputs go to reset values immediately. Deassertion is expected synchronous to clock.
- Flush and reset both take priority over issue and dispatch.

## Test plan
- Reset, then dispatch 3 lanes (classes 0/0/1, all rdy) → cycle +2: issue_valid = 0b0011, class 0 carries lane 0 payload; cycle +3: issue_valid = 0b0001 with lane 1 payload; free_cnt returns to 16.
- Dispatch lane 0 with tag1 = 0x12 not ready; 2 cycles later cdb_valid[2] = 1, cdb_tag[2] = 0x12 → issue_valid for its class in the next cycle.
- Same-cycle bypass: dispatch with tag2 = 0x05, rdy2 = 0 while cdb_tag[0] = 0x05 is valid → issues 2 cycles later, identical to a ready dispatch.
- Age order: fill entries 0..4 with class 2 waiting on tag 0x20, dispatched in the order slot 3, 1, 4, 0, 2; broadcast 0x20 → issue order over five cycles is 3, 1, 4, 0, 2. Hold fu_ready[2] = 0 for one cycle mid-sequence → no pulse that cycle, and order is preserved.
- Fill to free_cnt = 2, present 3 valid lanes → lanes 0 and 1 accepted, lane 2 dropped, overflow_err = 1 and stays set, free_cnt = 0, rs_full = 1.
- Flush with 10 entries valid and 3 lanes dispatching → next cycle free_cnt = 16, issue_valid = 0. Assert reset mid-issue → issue_valid drops without waiting for a clock edge.
